alu_request_arbiter: RTL and testbench

- Shares the single ALU datapath (ALU-op decode, logic, shift and carry units) between two requesters: requester 0 is the pipeline execute stage, requester 1 is the multi-byte/auxiliary sequencer.
- Arbitrates with round-robin priority and registers the winning op and operands onto the ALU inputs.
- Holds them stable for a programmable settle time, then captures the ALU result and flags and returns them to the granted requester with a one-cycle response strobe.

---
 rtl/alu_request_arbiter_if.sv | 49 ++++
 rtl/alu_request_arbiter.sv | 140 ++++++++++++++
 tb/tb_alu_request_arbiter.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_request_arbiter_if.sv
// Handshake and data bundle between the two ALU requesters, the shared ALU
// datapath and the arbiter that sits between them.
interface alu_request_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [3:0] req0_aluop;
  logic [7:0] req0_a;
  logic [7:0] req0_b;
  logic       req0_cin;

  logic       req1_valid;
  logic       req1_ready;
  logic [3:0] req1_aluop;
  logic [7:0] req1_a;
  logic [7:0] req1_b;
  logic       req1_cin;

  logic [3:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_cin;
  logic [7:0] alu_result;
  logic [3:0] alu_flags;

  logic       rsp0_valid;
  logic       rsp1_valid;
  logic [7:0] rsp_result;
  logic [3:0] rsp_flags;

  // Requester / ALU side.
  modport master (
    output req0_valid, req0_aluop, req0_a, req0_b, req0_cin,
    output req1_valid, req1_aluop, req1_a, req1_b, req1_cin,
    output alu_result, alu_flags,
    input  req0_ready, req1_ready,
    input  alu_op, alu_a, alu_b, alu_cin,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_flags
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_aluop, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_aluop, req1_a, req1_b, req1_cin,
    input  alu_result, alu_flags,
    output req0_ready, req1_ready,
    output alu_op, alu_a, alu_b, alu_cin,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_flags
  );
endinterface

// File: rtl/alu_request_arbiter.sv
// Round-robin arbiter sharing one ALU between the execute stage (req0) and
// the auxiliary sequencer (req1). The winning op is registered onto the ALU
// inputs, held for EXEC_CYCLES cycles, then the result/flags are captured
// and returned with a one-cycle strobe to the owning requester.
module alu_request_arbiter #(
  parameter int EXEC_CYCLES = 1  // 1..15
) (
  input logic               clk,
  input logic               rst_n,
  alu_request_arbiter_if.slave bus
);

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       last_grant;
  logic       owner;

  logic       open_win;
  logic       both;
  logic       win;
  logic       rdy0, rdy1;
  logic       accept;
  logic       cnt_zero;
  logic       capture;

  logic [3:0] sel_op;
  logic [7:0] sel_a, sel_b;
  logic       sel_cin;

  logic [3:0] op_q;
  logic [7:0] a_q, b_q;
  logic       cin_q;
  logic [7:0] res_q;
  logic [3:0] flg_q;

  // Grant: window open in IDLE/DONE; on contention the requester that did
  // not win last time goes first. Ready is masked while reset is asserted so
  // nothing is advertised during reset.
  always_comb begin
    open_win = rst_n && (state == IDLE || state == DONE);
    both     = bus.req0_valid && bus.req1_valid;
    win      = both ? ~last_grant : bus.req1_valid;
    rdy0     = open_win && bus.req0_valid && !win;
    rdy1     = open_win && bus.req1_valid &&  win;
    accept   = rdy0 || rdy1;
    cnt_zero = (cnt == 4'd0);
    capture  = (state == EXEC) && cnt_zero;
  end

  // Operand mux from the winning requester.
  always_comb begin
    if (win) begin
      sel_op  = bus.req1_aluop;
      sel_a   = bus.req1_a;
      sel_b   = bus.req1_b;
      sel_cin = bus.req1_cin;
    end else begin
      sel_op  = bus.req0_aluop;
      sel_a   = bus.req0_a;
      sel_b   = bus.req0_b;
      sel_cin = bus.req0_cin;
    end
  end

  // Next-state: DONE may immediately start the next op (back-to-back).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    if (cnt_zero) state_nxt = DONE;
      DONE:    state_nxt = accept ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, settle counter and grant history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt        <= CNT_LOAD;
        last_grant <= win;
        owner      <= win;
      end else if (state == EXEC && !cnt_zero) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // ALU input registers: change only on accept, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= 4'd0;
      a_q   <= 8'd0;
      b_q   <= 8'd0;
      cin_q <= 1'b0;
    end else if (accept) begin
      op_q  <= sel_op;
      a_q   <= sel_a;
      b_q   <= sel_b;
      cin_q <= sel_cin;
    end
  end

  // Result capture at the end of the last settle cycle; held until the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= 8'd0;
      flg_q <= 4'd0;
    end else if (capture) begin
      res_q <= bus.alu_result;
      flg_q <= bus.alu_flags;
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.alu_op     = op_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_cin    = cin_q;
  assign bus.rsp0_valid = (state == DONE) && !owner;
  assign bus.rsp1_valid = (state == DONE) &&  owner;
  assign bus.rsp_result = res_q;
  assign bus.rsp_flags  = flg_q;

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Bench for alu_request_arbiter: two instances (EXEC_CYCLES=1 and 3) driven
// each cycle and compared against a transaction-level timing model.
module tb_alu_request_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_request_arbiter_if bus1();
  alu_request_arbiter_if bus3();

  alu_request_arbiter #(.EXEC_CYCLES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  alu_request_arbiter #(.EXEC_CYCLES(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  // Stand-in ALU; ops 0x0 and 0xF behave as all-zero control.
  function automatic logic [7:0] fake_res(logic [3:0] op, logic [7:0] a, logic [7:0] b, logic cin);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    if (op == 4'h0 || op == 4'hF) return 8'h00;
    return s[7:0] ^ {op, op};
  endfunction

  function automatic logic [3:0] fake_flg(logic [3:0] op, logic [7:0] a, logic [7:0] b, logic cin);
    logic [8:0] s;
    logic [7:0] r;
    s = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    r = fake_res(op, a, b, cin);
    if (op == 4'h0 || op == 4'hF) return 4'h0;
    return {s[8], r == 8'h00, r[7], a[7] ^ b[7] ^ op[0]};
  endfunction

  assign bus1.alu_result = fake_res(bus1.alu_op, bus1.alu_a, bus1.alu_b, bus1.alu_cin);
  assign bus1.alu_flags  = fake_flg(bus1.alu_op, bus1.alu_a, bus1.alu_b, bus1.alu_cin);
  assign bus3.alu_result = fake_res(bus3.alu_op, bus3.alu_a, bus3.alu_b, bus3.alu_cin);
  assign bus3.alu_flags  = fake_flg(bus3.alu_op, bus3.alu_a, bus3.alu_b, bus3.alu_cin);

  typedef struct {
    logic       v;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
  } req_t;

  req_t s_req [2][2];  // [instance][requester]

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int base  = 0;

  // Model state per instance (0: EXEC_CYCLES=1, 1: EXEC_CYCLES=3).
  int         free_from [2];
  int         due       [2];
  logic       last      [2];
  logic       who       [2];
  logic [7:0] pend_res  [2];
  logic [3:0] pend_flg  [2];
  logic [3:0] e_op      [2];
  logic [7:0] e_a       [2];
  logic [7:0] e_b       [2];
  logic       e_cin     [2];
  logic [7:0] e_res     [2];
  logic [3:0] e_flg     [2];

  function automatic int ncyc(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic apply();
    bus1.req0_valid = s_req[0][0].v;  bus1.req0_aluop = s_req[0][0].op;
    bus1.req0_a     = s_req[0][0].a;  bus1.req0_b     = s_req[0][0].b;
    bus1.req0_cin   = s_req[0][0].cin;
    bus1.req1_valid = s_req[0][1].v;  bus1.req1_aluop = s_req[0][1].op;
    bus1.req1_a     = s_req[0][1].a;  bus1.req1_b     = s_req[0][1].b;
    bus1.req1_cin   = s_req[0][1].cin;
    bus3.req0_valid = s_req[1][0].v;  bus3.req0_aluop = s_req[1][0].op;
    bus3.req0_a     = s_req[1][0].a;  bus3.req0_b     = s_req[1][0].b;
    bus3.req0_cin   = s_req[1][0].cin;
    bus3.req1_valid = s_req[1][1].v;  bus3.req1_aluop = s_req[1][1].op;
    bus3.req1_a     = s_req[1][1].a;  bus3.req1_b     = s_req[1][1].b;
    bus3.req1_cin   = s_req[1][1].cin;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < 2; r++)
        s_req[i][r] = '{v: 1'b0, op: 4'h0, a: 8'h00, b: 8'h00, cin: 1'b0};
  endtask

  function automatic logic [36:0] observe(int i);
    if (i == 0)
      return {bus1.req0_ready, bus1.req1_ready, bus1.rsp0_valid, bus1.rsp1_valid,
              bus1.alu_op, bus1.alu_a, bus1.alu_b, bus1.alu_cin, bus1.rsp_result, bus1.rsp_flags};
    return {bus3.req0_ready, bus3.req1_ready, bus3.rsp0_valid, bus3.rsp1_valid,
            bus3.alu_op, bus3.alu_a, bus3.alu_b, bus3.alu_cin, bus3.rsp_result, bus3.rsp_flags};
  endfunction

  // {ready0, ready1} the rules call for this cycle.
  function automatic logic [1:0] exp_ready(int i);
    logic v0, v1, w;
    v0 = s_req[i][0].v;
    v1 = s_req[i][1].v;
    if (cyc < free_from[i] || !(v0 || v1)) return 2'b00;
    w = (v0 && v1) ? ~last[i] : v1;
    return w ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [36:0] expect_vec(int i);
    logic [1:0] rd;
    logic       strobe;
    rd     = exp_ready(i);
    strobe = (cyc == due[i]);
    return {rd, strobe && !who[i], strobe && who[i],
            e_op[i], e_a[i], e_b[i], e_cin[i], e_res[i], e_flg[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      free_from[i] = 0;   due[i] = -1;
      last[i] = 1'b1;     who[i] = 1'b0;
      pend_res[i] = '0;   pend_flg[i] = '0;
      e_op[i] = '0; e_a[i] = '0; e_b[i] = '0; e_cin[i] = 1'b0;
      e_res[i] = '0; e_flg[i] = '0;
    end
    cyc = 0;
  endtask

  // Advance the model across one rising edge.
  task automatic model_advance();
    logic [1:0] rd;
    logic       w;
    req_t       r;
    for (int i = 0; i < 2; i++) begin
      rd = exp_ready(i);
      if (rd != 2'b00) begin
        w = rd[0];
        r = s_req[i][w];
        e_op[i] = r.op; e_a[i] = r.a; e_b[i] = r.b; e_cin[i] = r.cin;
        last[i] = w;
        who[i]  = w;
        free_from[i] = cyc + ncyc(i) + 1;
        due[i]       = cyc + ncyc(i) + 1;
        pend_res[i]  = fake_res(r.op, r.a, r.b, r.cin);
        pend_flg[i]  = fake_flg(r.op, r.a, r.b, r.cin);
      end
    end
    cyc++;
    for (int i = 0; i < 2; i++)
      if (cyc == due[i]) begin
        e_res[i] = pend_res[i];
        e_flg[i] = pend_flg[i];
      end
  endtask

  // Entered and left at a falling edge; the cycle after release is cycle 0.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_reqs();
    apply();
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    base = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_reqs();
    apply();
    #1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (observe(i) !== 37'd0) begin
        bad++;
        $display("FAIL reset_state inst%0d got=%h want=%h", i, observe(i), 37'd0);
      end
    end
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_single_req0();
    logic [7:0] samp;
    do_reset();
    s_req[0][0] = '{v: 1'b1, op: 4'hA, a: 8'h5C, b: 8'h01, cin: 1'b0};
    samp = 8'h00;
    for (int rel = 0; rel < 6; rel++) begin
      apply(); #1;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (observe(i) !== expect_vec(i)) begin
          bad++;
          $display("FAIL single_req0 inst%0d rel%0d got=%h want=%h", i, rel, observe(i), expect_vec(i));
        end
      end
      if (rel == 0) begin
        total++;
        if (bus1.req0_ready !== 1'b1) begin
          bad++; $display("FAIL single_ready0 got=%b want=1", bus1.req0_ready);
        end
      end
      if (rel == 1) begin
        samp = bus1.alu_result;
        total++;
        if (bus1.alu_op !== 4'hA) begin
          bad++; $display("FAIL single_aluop got=%h want=a", bus1.alu_op);
        end
      end
      if (rel == 2) begin
        total++;
        if (bus1.rsp0_valid !== 1'b1 || bus1.rsp_result !== samp) begin
          bad++; $display("FAIL single_rsp got=%b/%h want=1/%h", bus1.rsp0_valid, bus1.rsp_result, samp);
        end
      end
      if (rel == 3) begin
        total++;
        if (bus1.rsp0_valid !== 1'b0) begin
          bad++; $display("FAIL single_pulse got=%b want=0", bus1.rsp0_valid);
        end
      end
      model_advance();
      @(negedge clk);
    end
  endtask

  task automatic test_alternate();
    do_reset();
    s_req[0][0] = '{v: 1'b1, op: 4'h3, a: 8'h11, b: 8'h22, cin: 1'b0};
    s_req[0][1] = '{v: 1'b1, op: 4'h4, a: 8'h33, b: 8'h44, cin: 1'b1};
    for (int rel = 0; rel < 10; rel++) begin
      apply(); #1;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (observe(i) !== expect_vec(i)) begin
          bad++;
          $display("FAIL alternate inst%0d rel%0d got=%h want=%h", i, rel, observe(i), expect_vec(i));
        end
      end
      total++;
      if (bus1.req0_ready && bus1.req1_ready) begin
        bad++; $display("FAIL alternate_both_ready rel%0d got=11 want=one-hot", rel);
      end
      if (rel % 2 == 0) begin
        total++;
        if ({bus1.req0_ready, bus1.req1_ready} !== (((rel / 2) % 2 == 0) ? 2'b10 : 2'b01)) begin
          bad++;
          $display("FAIL alternate_grant rel%0d got=%b%b want=%s", rel, bus1.req0_ready,
                   bus1.req1_ready, ((rel / 2) % 2 == 0) ? "req0" : "req1");
        end
      end
      model_advance();
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int rel = 0; rel < 8; rel++) begin
      s_req[0][1] = '{v: 1'b1, op: 4'($urandom_range(1, 14)), a: 8'($urandom), b: 8'($urandom),
                      cin: 1'($urandom)};
      apply(); #1;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (observe(i) !== expect_vec(i)) begin
          bad++;
          $display("FAIL back_to_back inst%0d rel%0d got=%h want=%h", i, rel, observe(i), expect_vec(i));
        end
      end
      total++;
      if (bus1.req1_ready !== (rel % 2 == 0) ||
          bus1.rsp1_valid !== (rel >= 2 && rel % 2 == 0)) begin
        bad++;
        $display("FAIL b2b_timing rel%0d got=rdy%b rsp%b want=rdy%b rsp%b", rel, bus1.req1_ready,
                 bus1.rsp1_valid, rel % 2 == 0, rel >= 2 && rel % 2 == 0);
      end
      model_advance();
      @(negedge clk);
    end
  endtask

  task automatic test_exec3();
    do_reset();
    s_req[1][0] = '{v: 1'b1, op: 4'h7, a: 8'hFF, b: 8'h01, cin: 1'b1};
    for (int rel = 0; rel < 7; rel++) begin
      apply(); #1;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (observe(i) !== expect_vec(i)) begin
          bad++;
          $display("FAIL exec3 inst%0d rel%0d got=%h want=%h", i, rel, observe(i), expect_vec(i));
        end
      end
      if (rel >= 1 && rel <= 3) begin
        total++;
        if (bus3.req0_ready !== 1'b0) begin
          bad++; $display("FAIL exec3_stall rel%0d got=%b want=0", rel, bus3.req0_ready);
        end
      end
      if (rel == 4) begin
        total++;
        if (bus3.rsp0_valid !== 1'b1 || bus3.rsp_result !== 8'h76 || bus3.rsp_flags !== 4'b1000) begin
          bad++;
          $display("FAIL exec3_rsp got=%b/%h/%h want=1/76/8", bus3.rsp0_valid, bus3.rsp_result, bus3.rsp_flags);
        end
      end
      model_advance();
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    s_req[1][0] = '{v: 1'b1, op: 4'h2, a: 8'h40, b: 8'h41, cin: 1'b0};
    for (int rel = 0; rel < 3; rel++) begin
      if (rel == 1) s_req[1][1] = '{v: 1'b1, op: 4'h5, a: 8'h0F, b: 8'hF0, cin: 1'b1};
      apply(); #1;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (observe(i) !== expect_vec(i)) begin
          bad++;
          $display("FAIL rst_mid inst%0d rel%0d got=%h want=%h", i, rel, observe(i), expect_vec(i));
        end
      end
      if (rel < 2) begin
        model_advance();
        @(negedge clk);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (observe(i) !== 37'd0) begin
        bad++; $display("FAIL rst_mid_async inst%0d got=%h want=%h", i, observe(i), 37'd0);
      end
    end
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int rel = 0; rel < 6; rel++) begin
      apply(); #1;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (observe(i) !== expect_vec(i)) begin
          bad++;
          $display("FAIL rst_mid_after inst%0d rel%0d got=%h want=%h", i, rel, observe(i), expect_vec(i));
        end
      end
      if (rel == 0) begin
        total++;
        if ({bus3.req0_ready, bus3.req1_ready} !== 2'b10) begin
          bad++; $display("FAIL rst_mid_first_grant got=%b%b want=10", bus3.req0_ready, bus3.req1_ready);
        end
      end
      if (rel < 4) begin
        total++;
        if (bus3.rsp0_valid !== 1'b0 || bus3.rsp1_valid !== 1'b0) begin
          bad++; $display("FAIL rst_mid_no_rsp rel%0d got=%b%b want=00", rel, bus3.rsp0_valid, bus3.rsp1_valid);
        end
      end
      model_advance();
      @(negedge clk);
    end
  endtask

  task automatic test_opcode_f();
    do_reset();
    s_req[0][1] = '{v: 1'b1, op: 4'hF, a: 8'($urandom_range(1, 255)), b: 8'($urandom), cin: 1'b1};
    for (int rel = 0; rel < 4; rel++) begin
      if (rel == 1) s_req[0][1].v = 1'b0;
      apply(); #1;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (observe(i) !== expect_vec(i)) begin
          bad++;
          $display("FAIL opcode_f inst%0d rel%0d got=%h want=%h", i, rel, observe(i), expect_vec(i));
        end
      end
      if (rel == 1) begin
        total++;
        if (bus1.alu_op !== 4'hF) begin
          bad++; $display("FAIL opcode_f_fwd got=%h want=f", bus1.alu_op);
        end
      end
      if (rel == 2) begin
        total++;
        if (bus1.rsp1_valid !== 1'b1 || bus1.rsp_result !== 8'h00) begin
          bad++; $display("FAIL opcode_f_rsp got=%b/%h want=1/00", bus1.rsp1_valid, bus1.rsp_result);
        end
      end
      model_advance();
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int rel = 0; rel < 400; rel++) begin
      for (int i = 0; i < 2; i++)
        for (int r = 0; r < 2; r++)
          s_req[i][r] = '{v: ($urandom_range(0, 2) != 0), op: 4'($urandom), a: 8'($urandom),
                          b: 8'($urandom), cin: 1'($urandom)};
      apply(); #1;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (observe(i) !== expect_vec(i)) begin
          bad++;
          $display("FAIL random inst%0d rel%0d got=%h want=%h", i, rel, observe(i), expect_vec(i));
        end
      end
      model_advance();
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_reqs();
    apply();
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_req0();
    test_alternate();
    test_back_to_back();
    test_exec3();
    test_reset_mid_exec();
    test_opcode_f();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
